// File: rtl/wait_arb_pkg.sv
// -----------------------------------------------------------------------------
// wait_arb_pkg
// Shared definitions for the wait_arbiter codebase slice:
//   - arb_state_e : arbiter FSM states (IDLE, COUNT, DONE)
//   - CW_DEFAULT  : default width of a requester's cycle count
//   - MAX_REQ     : largest supported requester count
//   - rr_winner() : round-robin winner search starting at a pointer
// -----------------------------------------------------------------------------
package wait_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } arb_state_e;

  localparam int unsigned CW_DEFAULT = 32;
  localparam int unsigned MAX_REQ    = 16;

  // Search upward from ptr, wrapping at n_req; first asserted bit wins.
  // Returns 0 when nothing is requested (caller only uses it when |req).
  function automatic logic [3:0] rr_winner(input logic [MAX_REQ-1:0] req,
                                           input logic [3:0]         ptr,
                                           input int unsigned        n_req);
    logic [3:0]  win;
    logic        found;
    int unsigned idx;
    win   = 4'd0;
    found = 1'b0;
    for (int unsigned i = 0; i < MAX_REQ; i++) begin
      idx = (32'(ptr) + i) % n_req;
      if (!found && (i < n_req) && req[idx[3:0]]) begin
        win   = idx[3:0];
        found = 1'b1;
      end else begin
        win   = win;
        found = found;
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/wait_arb_timer.sv
// -----------------------------------------------------------------------------
// wait_arb_timer
// Shared countdown timer. Loads a cycle count and decrements it once per clock
// until it reaches zero; it never wraps below zero.
// Ports:
//   clk      : clock
//   rst      : asynchronous active-low reset
//   load     : load load_val into the counter this edge
//   load_val : count to load (CW bits)
//   zero     : counter is zero
//   busy     : counter is non-zero (still counting)
// -----------------------------------------------------------------------------
module wait_arb_timer
  import wait_arb_pkg::*;
#(
  parameter int unsigned CW = CW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  output logic          zero,
  output logic          busy
);

  logic [CW-1:0] cycles_left_r;

  // Countdown register: load has priority, otherwise saturating decrement.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cycles_left_r <= '0;
    end else if (load) begin
      cycles_left_r <= load_val;
    end else if (cycles_left_r != '0) begin
      cycles_left_r <= cycles_left_r - {{(CW-1){1'b0}}, 1'b1};
    end else begin
      cycles_left_r <= cycles_left_r;
    end
  end

  assign zero = (cycles_left_r == '0);
  assign busy = (cycles_left_r != '0);

endmodule

// File: rtl/wait_arbiter.sv
// -----------------------------------------------------------------------------
// wait_arbiter
// Shares one countdown timer among N_REQ requesters. One requester is granted
// at a time, its cycle count is counted down, and a one-cycle ack is returned.
// Arbitration is round-robin by default; defining WAIT_ARB_FIXED_PRIO_EN
// selects fixed priority (lowest index wins) and removes the pointer register.
// Ports:
//   clk     : clock
//   rst     : asynchronous active-low reset
//   req     : per-requester level request, held until ack
//   cycles  : requester i count in bits [i*CW +: CW]
//   ack     : one-cycle completion pulse (one-hot or zero)
//   busy    : high while a request is served (COUNT or DONE)
//   gnt_idx : index of the current or last granted requester
// -----------------------------------------------------------------------------
module wait_arbiter
  import wait_arb_pkg::*;
#(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned CW    = CW_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ*CW-1:0]      cycles,
  output logic [N_REQ-1:0]         ack,
  output logic                     busy,
  output logic [$clog2(N_REQ)-1:0] gnt_idx
);

  localparam int unsigned IW = $clog2(N_REQ);
  localparam logic [N_REQ-1:0] ACK_ONE = {{(N_REQ-1){1'b0}}, 1'b1};

  arb_state_e         state_r, state_nxt_s;
  logic [N_REQ-1:0]   ack_r, ack_nxt_s;
  logic               busy_r, busy_nxt_s;
  logic [IW-1:0]      gnt_idx_r, gnt_nxt_s;
  logic [MAX_REQ-1:0] req_pad_s;
  logic [3:0]         win_full_s;
  logic [IW-1:0]      winner_s;
  logic [CW-1:0]      load_val_s;
  logic               load_s;
  logic               timer_zero_s;
  logic               timer_busy_s;

  assign req_pad_s = MAX_REQ'(req);
  assign winner_s  = IW'(win_full_s);

`ifdef WAIT_ARB_FIXED_PRIO_EN
  // Fixed priority is the round-robin search anchored permanently at 0.
  assign win_full_s = rr_winner(req_pad_s, 4'd0, N_REQ);
`else
  logic [IW-1:0] ptr_r, ptr_nxt_s;

  assign win_full_s = rr_winner(req_pad_s, 4'(ptr_r), N_REQ);

  // Round-robin pointer register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_r <= '0;
    end else begin
      ptr_r <= ptr_nxt_s;
    end
  end

  // Pointer moves past the served requester only when its service finishes.
  always_comb begin
    ptr_nxt_s = ptr_r;
    if (state_r == DONE) begin
      if (gnt_idx_r == IW'(N_REQ - 1)) begin
        ptr_nxt_s = '0;
      end else begin
        ptr_nxt_s = gnt_idx_r + {{(IW-1){1'b0}}, 1'b1};
      end
    end else begin
      ptr_nxt_s = ptr_r;
    end
  end
`endif

  // Select the winner's cycle count for loading into the timer.
  always_comb begin
    load_val_s = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (winner_s == IW'(i)) begin
        load_val_s = cycles[i*CW +: CW];
      end else begin
        load_val_s = load_val_s;
      end
    end
  end

  wait_arb_timer #(
    .CW (CW)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (load_s),
    .load_val (load_val_s),
    .zero     (timer_zero_s),
    .busy     (timer_busy_s)
  );

  // FSM state and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= IDLE;
      ack_r     <= '0;
      busy_r    <= 1'b0;
      gnt_idx_r <= '0;
    end else begin
      state_r   <= state_nxt_s;
      ack_r     <= ack_nxt_s;
      busy_r    <= busy_nxt_s;
      gnt_idx_r <= gnt_nxt_s;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_nxt_s = state_r;
    ack_nxt_s   = '0;
    busy_nxt_s  = busy_r;
    gnt_nxt_s   = gnt_idx_r;
    load_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (|req) begin
          load_s      = 1'b1;
          gnt_nxt_s   = winner_s;
          busy_nxt_s  = 1'b1;
          state_nxt_s = COUNT;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      COUNT: begin
        if (timer_zero_s) begin
          ack_nxt_s   = ACK_ONE << gnt_idx_r;
          state_nxt_s = DONE;
        end else if (timer_busy_s) begin
          state_nxt_s = COUNT;
        end else begin
          // Unreachable (zero and busy are complementary): recover to IDLE.
          busy_nxt_s  = 1'b0;
          state_nxt_s = IDLE;
        end
      end
      DONE: begin
        busy_nxt_s  = 1'b0;
        state_nxt_s = IDLE;
      end
      default: begin
        busy_nxt_s  = 1'b0;
        state_nxt_s = IDLE;
      end
    endcase
  end

  assign ack     = ack_r;
  assign busy    = busy_r;
  assign gnt_idx = gnt_idx_r;

endmodule

// File: tb/tb_wait_arbiter.sv
// -----------------------------------------------------------------------------
// tb_wait_arbiter
// Directed self-checking bench for wait_arbiter: a 4x32 instance for the main
// scenarios and a 4x8 instance for the full-scale count.
// -----------------------------------------------------------------------------
module tb_wait_arbiter;

  logic         clk;
  logic         rst;
  logic [3:0]   req;
  logic [127:0] cycles;
  logic [3:0]   ack;
  logic         busy;
  logic [1:0]   gnt_idx;

  logic [3:0]   req8;
  logic [31:0]  cycles8;
  logic [3:0]   ack8;
  logic         busy8;
  logic [1:0]   gnt8;

  int n_cmp;
  int n_err;

  wait_arbiter #(.N_REQ(4), .CW(32)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .cycles  (cycles),
    .ack     (ack),
    .busy    (busy),
    .gnt_idx (gnt_idx)
  );

  wait_arbiter #(.N_REQ(4), .CW(8)) dut8 (
    .clk     (clk),
    .rst     (rst),
    .req     (req8),
    .cycles  (cycles8),
    .ack     (ack8),
    .busy    (busy8),
    .gnt_idx (gnt8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req = 4'b0000;
    cycles = '0;
    req8 = 4'b0000;
    cycles8 = '0;
    #2 rst = 1'b0;
    #1;
    n_cmp++; if (ack !== 4'b0000) begin n_err++; $display("FAIL reset_ack got %b want 0000", ack); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
    n_cmp++; if (gnt_idx !== 2'd0) begin n_err++; $display("FAIL reset_gnt got %0d want 0", gnt_idx); end
    tick();
    tick();
    rst = 1'b1;
    tick();
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL idle_busy got %b want 0", busy); end
  endtask

  // C=5 on requester 0: ack exactly at E0+6, busy E0..E0+6.
  task automatic test_single();
    cycles[0*32 +: 32] = 32'd5;
    req = 4'b0001;
    tick(); // E0
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL single_busy_e0 got %b want 1", busy); end
    n_cmp++; if (gnt_idx !== 2'd0) begin n_err++; $display("FAIL single_gnt got %0d want 0", gnt_idx); end
    for (int k = 1; k <= 7; k++) begin
      tick();
      n_cmp++;
      if (ack !== ((k == 6) ? 4'b0001 : 4'b0000)) begin
        n_err++; $display("FAIL single_ack E0+%0d got %b want %b", k, ack, (k == 6) ? 4'b0001 : 4'b0000);
      end
      n_cmp++;
      if (busy !== (k <= 6)) begin
        n_err++; $display("FAIL single_busy E0+%0d got %b want %b", k, busy, (k <= 6));
      end
      if (k == 6) req = 4'b0000;
    end
  endtask

  // C=0 on requester 2: ack at E0+1, busy drops E0+2, re-grant at E0+3.
  task automatic test_zero();
    cycles[2*32 +: 32] = 32'd0;
    req = 4'b0100;
    tick(); // E0
    n_cmp++; if (gnt_idx !== 2'd2) begin n_err++; $display("FAIL zero_gnt got %0d want 2", gnt_idx); end
    tick();
    n_cmp++; if (ack !== 4'b0100) begin n_err++; $display("FAIL zero_ack got %b want 0100", ack); end
    tick();
    n_cmp++; if (ack !== 4'b0000) begin n_err++; $display("FAIL zero_ack_fall got %b want 0000", ack); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL zero_busy_fall got %b want 0", busy); end
    tick(); // E0+3: held request granted again
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL zero_regrant_busy got %b want 1", busy); end
    n_cmp++; if (gnt_idx !== 2'd2) begin n_err++; $display("FAIL zero_regrant_gnt got %0d want 2", gnt_idx); end
    req = 4'b0000; // withdrawn, service still completes
    tick();
    n_cmp++; if (ack !== 4'b0100) begin n_err++; $display("FAIL zero_withdraw_ack got %b want 0100", ack); end
    tick();
    tick();
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL zero_end_busy got %b want 0", busy); end
  endtask

  // All four requesting with C=1: 4-cycle period, order 0,1,2,3,0.
  task automatic test_round_robin();
    logic [1:0] order [5];
`ifdef WAIT_ARB_FIXED_PRIO_EN
    order = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
`else
    order = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
`endif
    rst = 1'b0; // restart from pointer 0
    tick();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) cycles[i*32 +: 32] = 32'd1;
    req = 4'b1111;
    for (int j = 0; j < 20; j++) begin
      tick(); // E0+j
      if (j % 4 == 0) begin
        n_cmp++;
        if (gnt_idx !== order[j/4]) begin
          n_err++; $display("FAIL rr_gnt grant %0d got %0d want %0d", j/4, gnt_idx, order[j/4]);
        end
      end
      n_cmp++;
      if (ack !== ((j % 4 == 2) ? (4'b0001 << order[j/4]) : 4'b0000)) begin
        n_err++; $display("FAIL rr_ack E0+%0d got %b want %b", j, ack,
                          (j % 4 == 2) ? (4'b0001 << order[j/4]) : 4'b0000);
      end
    end
    req = 4'b0000;
    tick();
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rr_end_busy got %b want 0", busy); end
  endtask

  // Serve req[1] (C=10); req[3] arrives and req[1] drops mid-count.
  task automatic test_late_withdraw();
    cycles[1*32 +: 32] = 32'd10;
    cycles[3*32 +: 32] = 32'd2;
    req = 4'b0010;
    tick(); // E0
    n_cmp++; if (gnt_idx !== 2'd1) begin n_err++; $display("FAIL late_gnt1 got %0d want 1", gnt_idx); end
    for (int j = 1; j <= 13; j++) begin
      tick();
      if (j == 3) req = 4'b1000;
      n_cmp++;
      if (ack !== ((j == 11) ? 4'b0010 : 4'b0000)) begin
        n_err++; $display("FAIL late_ack E0+%0d got %b want %b", j, ack, (j == 11) ? 4'b0010 : 4'b0000);
      end
      if (j == 12) begin
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL late_busy_gap got %b want 0", busy); end
      end
    end
    n_cmp++; if (gnt_idx !== 2'd3) begin n_err++; $display("FAIL late_gnt3 got %0d want 3", gnt_idx); end
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL late_busy3 got %b want 1", busy); end
    req = 4'b0000;
    tick();
    tick();
    tick();
    n_cmp++; if (ack !== 4'b1000) begin n_err++; $display("FAIL late_ack3 got %b want 1000", ack); end
    tick();
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL late_end_busy got %b want 0", busy); end
  endtask

  // Reset at E0+20 of a C=100 request aborts it; a fresh grant follows.
  task automatic test_reset_mid();
    cycles[2*32 +: 32] = 32'd100;
    req = 4'b0100;
    tick(); // E0
    for (int j = 1; j <= 20; j++) tick();
    n_cmp++; if (gnt_idx !== 2'd2) begin n_err++; $display("FAIL rmid_gnt_pre got %0d want 2", gnt_idx); end
    rst = 1'b0;
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rmid_busy got %b want 0", busy); end
    n_cmp++; if (gnt_idx !== 2'd0) begin n_err++; $display("FAIL rmid_gnt got %0d want 0", gnt_idx); end
    n_cmp++; if (ack !== 4'b0000) begin n_err++; $display("FAIL rmid_ack got %b want 0000", ack); end
    #3 rst = 1'b1;
    tick(); // new grant edge
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL rmid_regrant_busy got %b want 1", busy); end
    n_cmp++; if (gnt_idx !== 2'd2) begin n_err++; $display("FAIL rmid_regrant_gnt got %0d want 2", gnt_idx); end
    for (int j = 1; j <= 100; j++) tick();
    n_cmp++; if (ack !== 4'b0000) begin n_err++; $display("FAIL rmid_ack_early got %b want 0000", ack); end
    tick();
    n_cmp++; if (ack !== 4'b0100) begin n_err++; $display("FAIL rmid_ack101 got %b want 0100", ack); end
    req = 4'b0000;
    tick();
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rmid_end_busy got %b want 0", busy); end
  endtask

  // CW=8 with 8'hFF: ack only at E0+256, no wrap.
  task automatic test_max_count();
    cycles8[1*8 +: 8] = 8'hFF;
    req8 = 4'b0010;
    tick(); // E0
    n_cmp++; if (gnt8 !== 2'd1) begin n_err++; $display("FAIL max_gnt got %0d want 1", gnt8); end
    for (int j = 1; j <= 257; j++) begin
      tick();
      if (j == 256) req8 = 4'b0000;
      n_cmp++;
      if (ack8 !== ((j == 256) ? 4'b0010 : 4'b0000)) begin
        n_err++; $display("FAIL max_ack E0+%0d got %b want %b", j, ack8, (j == 256) ? 4'b0010 : 4'b0000);
      end
    end
    n_cmp++; if (busy8 !== 1'b0) begin n_err++; $display("FAIL max_end_busy got %b want 0", busy8); end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_single();
    test_zero();
    test_round_robin();
    test_late_withdraw();
    test_reset_mid();
    test_max_count();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
